// File: rtl/blast_pkg.sv
// rtl/blast_pkg.sv - shared constants, hit record layout and writer state encoding
package blast_pkg;

    localparam int MEMORY_DATAWIDTH   = 64;
    localparam int MEMORY_ADDRESS     = 14;
    localparam int LENGTH_COUNTER     = 8;
    localparam int MEM_HIT_SCORE_ADDR = 16262;

    typedef struct packed {
        logic [LENGTH_COUNTER-1:0] q_addr;
        logic [LENGTH_COUNTER-1:0] s_addr;
        logic [LENGTH_COUNTER-1:0] length;
        logic [LENGTH_COUNTER-1:0] score;
    } hit_record_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLUSH,
        ST_HEADER
    } writer_state_t;

endpackage

// File: rtl/hit_record_writer_if.sv
// rtl/hit_record_writer_if.sv - hit record stream and port-2 memory write bus
import blast_pkg::*;

interface hit_record_writer_if;

    logic                          hit_valid;
    logic                          hit_ready;
    logic [LENGTH_COUNTER-1:0]     hit_add_inQ;
    logic [LENGTH_COUNTER-1:0]     hit_add_inS;
    logic [LENGTH_COUNTER-1:0]     hit_length;
    logic [LENGTH_COUNTER-1:0]     hit_score;

    logic                          mem_grant;
    logic [MEMORY_ADDRESS-1:0]     memory_address;
    logic                          memory_write;
    logic [MEMORY_DATAWIDTH-1:0]   memory_writedata;
    logic [MEMORY_DATAWIDTH/8-1:0] memory_byteenable;

    modport master (
        output hit_valid, hit_add_inQ, hit_add_inS, hit_length, hit_score, mem_grant,
        input  hit_ready, memory_address, memory_write, memory_writedata, memory_byteenable
    );

    modport slave (
        input  hit_valid, hit_add_inQ, hit_add_inS, hit_length, hit_score, mem_grant,
        output hit_ready, memory_address, memory_write, memory_writedata, memory_byteenable
    );

endinterface

// File: rtl/hit_fifo.sv
// rtl/hit_fifo.sv - synchronous record FIFO with combinational head and registered pointers
module hit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full     = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign empty    = (wptr == rptr);
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hit_record_writer.sv
// rtl/hit_record_writer.sv - packs hit records two per word into the hit-score area, header on flush
import blast_pkg::*;

module hit_record_writer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    hit_record_writer_if.slave  bus,
    input  logic [31:0]         subject_ID,
    input  logic                flush,
    output logic                flush_done,
    output logic [31:0]         hit_count,
    output logic                overflow
);

    localparam logic [MEMORY_ADDRESS-1:0] HDR_ADDR = MEMORY_ADDRESS'(MEM_HIT_SCORE_ADDR);
    localparam logic [MEMORY_ADDRESS-1:0] REC_BASE = MEMORY_ADDRESS'(MEM_HIT_SCORE_ADDR + 1);
    localparam logic [MEMORY_ADDRESS-1:0] ADDR_MAX = '1;

    writer_state_t             state;
    hit_record_t               in_rec;
    hit_record_t               head_rec;
    hit_record_t               pending_rec;
    logic                      pending_valid;
    logic                      flushing;
    logic                      write_pops;
    logic [31:0]               subject_latched;
    logic [MEMORY_ADDRESS-1:0] rec_addr;
    logic [MEMORY_ADDRESS-1:0] next_addr;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      load_pending;
    logic                      commit;

    assign in_rec    = {bus.hit_add_inQ, bus.hit_add_inS, bus.hit_length, bus.hit_score};
    assign bus.hit_ready = !fifo_full && !flushing && (state != ST_HEADER);
    assign bus.memory_byteenable = '1;

    assign push      = bus.hit_valid && bus.hit_ready;
    assign commit    = bus.memory_write && bus.mem_grant;
    assign next_addr = (rec_addr == ADDR_MAX) ? REC_BASE : rec_addr + 1'b1;

    // The second record of a pair stays at the FIFO head until its word commits,
    // so the written word is stable and a stalled port back-pressures the FIFO.
    assign load_pending = ((state == ST_IDLE) || (state == ST_FLUSH)) && !pending_valid && !fifo_empty;
    assign pop          = load_pending || ((state == ST_WRITE) && commit && write_pops);

    hit_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            pending_rec          <= '0;
            pending_valid        <= 1'b0;
            flushing             <= 1'b0;
            write_pops           <= 1'b0;
            subject_latched      <= '0;
            rec_addr             <= REC_BASE;
            bus.memory_address   <= REC_BASE;
            bus.memory_write     <= 1'b0;
            bus.memory_writedata <= '0;
            flush_done           <= 1'b0;
            hit_count            <= '0;
            overflow             <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (push && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            if (load_pending) begin
                pending_rec   <= head_rec;
                pending_valid <= 1'b1;
            end
            if (flush && !flushing) begin
                flushing        <= 1'b1;
                subject_latched <= subject_ID;
            end

            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end else if (pending_valid && !fifo_empty) begin
                        bus.memory_writedata <= {head_rec, pending_rec};
                        bus.memory_address   <= rec_addr;
                        bus.memory_write     <= 1'b1;
                        write_pops           <= 1'b1;
                        state                <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (commit) begin
                        bus.memory_write   <= 1'b0;
                        pending_valid      <= 1'b0;
                        rec_addr           <= next_addr;
                        bus.memory_address <= next_addr;
                        if (rec_addr == ADDR_MAX) overflow <= 1'b1;
                        state <= (flushing || flush) ? ST_FLUSH : ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (pending_valid) begin
                        bus.memory_writedata <= fifo_empty ? {{32{1'b0}}, pending_rec}
                                                           : {head_rec, pending_rec};
                        bus.memory_address   <= rec_addr;
                        bus.memory_write     <= 1'b1;
                        write_pops           <= !fifo_empty;
                        state                <= ST_WRITE;
                    end else if (fifo_empty) begin
                        bus.memory_writedata <= {subject_latched, hit_count};
                        bus.memory_address   <= HDR_ADDR;
                        bus.memory_write     <= 1'b1;
                        state                <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (commit) begin
                        bus.memory_write   <= 1'b0;
                        flush_done         <= 1'b1;
                        hit_count          <= '0;
                        overflow           <= 1'b0;
                        rec_addr           <= REC_BASE;
                        bus.memory_address <= REC_BASE;
                        flushing           <= 1'b0;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
